// File: rtl/stack_pkg.sv
// Shared types and default geometry for the 4-bit stack command driver.
package stack_pkg;

    localparam int unsigned STK_DATA_W   = 4;
    localparam int unsigned STK_IDX_W    = 3;
    localparam int unsigned STK_DEPTH    = 5;
    localparam int unsigned STK_HOLD_CYC = 2;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_RESP
    } drv_state_e;

endpackage

// File: rtl/stack_cmd_driver_if.sv
// Request/response port of the stack command driver; master is the CPU/FSM side.
interface stack_cmd_driver_if
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W = STK_DATA_W,
    parameter int unsigned IDX_W  = STK_IDX_W
) ();

    logic              req_valid;
    logic              req_ready;
    cmd_e              req_cmd;
    logic [IDX_W-1:0]  req_index;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_cmd, req_index, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_cmd, req_index, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/stack_drv_occ.sv
// Occupancy tracker for the driven stack: counts 0..DEPTH and flags over/underflow
// and out-of-range GETs. Only built when STACK_DRV_OCC_CHECK_EN is defined.
module stack_drv_occ
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH = STK_DEPTH,
    parameter int unsigned IDX_W = STK_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_i,
    input  cmd_e             cmd_i,
    input  logic [IDX_W-1:0] index_i,
    output logic             err_o,
    output logic             force_zero_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] count_q, count_d;

    always_comb begin
        count_d      = count_q;
        err_o        = 1'b0;
        force_zero_o = 1'b0;
        unique case (cmd_i)
            CMD_PUSH: begin
                // Full stack still takes the push (it overwrites the oldest cell).
                if (count_q == OCC_W'(DEPTH)) begin
                    err_o = 1'b1;
                end else begin
                    count_d = count_q + OCC_W'(1);
                end
            end
            CMD_POP: begin
                if (count_q == '0) begin
                    err_o        = 1'b1;
                    force_zero_o = 1'b1;
                end else begin
                    count_d = count_q - OCC_W'(1);
                end
            end
            CMD_GET: begin
                if (32'(index_i) >= 32'(count_q)) begin
                    err_o        = 1'b1;
                    force_zero_o = 1'b1;
                end
            end
            CMD_NOP: ;
        endcase
        if (!upd_i) begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stack_cmd_driver.sv
// Initiator for the 4-bit stack COMMAND/INDEX/I_DATA -> O_DATA pins: one request at a time,
// each command held HOLD_CYC clocks. Optional occupancy checking via STACK_DRV_OCC_CHECK_EN.
module stack_cmd_driver
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W   = STK_DATA_W,
    parameter int unsigned IDX_W    = STK_IDX_W,
    parameter int unsigned HOLD_CYC = STK_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    stack_cmd_driver_if.slave bus,
    output cmd_e              stk_command,
    output logic [IDX_W-1:0]  stk_index,
    output logic [DATA_W-1:0] stk_data,
    input  logic [DATA_W-1:0] stk_o_data
);

    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    drv_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    cmd_e              stk_cmd_q, stk_cmd_d;
    logic [IDX_W-1:0]  stk_idx_q, stk_idx_d;
    logic [DATA_W-1:0] stk_data_q, stk_data_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic occ_upd;
    logic occ_err;
    logic occ_force_zero;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stk_cmd_d   = stk_cmd_q;
        stk_idx_d   = stk_idx_q;
        stk_data_d  = stk_data_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        occ_upd     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    ready_d = 1'b0;
                    if (bus.req_cmd == CMD_NOP) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d    = S_DRIVE;
                        hold_d     = HOLD_W'(HOLD_CYC - 1);
                        stk_cmd_d  = bus.req_cmd;
                        stk_idx_d  = bus.req_index;
                        stk_data_d = bus.req_data;
                    end
                end
            end
            S_DRIVE: begin
                if (hold_q == '0) begin
                    // Last held edge: sample the stack output and release the pins.
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = occ_err;
                    occ_upd     = 1'b1;
                    if ((stk_cmd_q == CMD_POP || stk_cmd_q == CMD_GET) && !occ_force_zero) begin
                        rsp_data_d = stk_o_data;
                    end else begin
                        rsp_data_d = '0;
                    end
                    stk_cmd_d  = CMD_NOP;
                    stk_idx_d  = '0;
                    stk_data_d = '0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            stk_cmd_q   <= CMD_NOP;
            stk_idx_q   <= '0;
            stk_data_q  <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stk_cmd_q   <= stk_cmd_d;
            stk_idx_q   <= stk_idx_d;
            stk_data_q  <= stk_data_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef STACK_DRV_OCC_CHECK_EN
    stack_drv_occ #(
        .IDX_W(IDX_W)
    ) u_occ (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_i       (occ_upd),
        .cmd_i       (stk_cmd_q),
        .index_i     (stk_idx_q),
        .err_o       (occ_err),
        .force_zero_o(occ_force_zero)
    );
`else
    logic unused_occ_upd;
    assign unused_occ_upd = occ_upd;
    assign occ_err        = 1'b0;
    assign occ_force_zero = 1'b0;
`endif

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign stk_command   = stk_cmd_q;
    assign stk_index     = stk_idx_q;
    assign stk_data      = stk_data_q;

endmodule
